enc4x2_seq: RTL

Registered 4-to-2 priority encoder with valid/ready handshake: the inverse of the team's 2x4 positive-output decoder, turning a 4-bit one-hot (or multi-hot) request vector back into a 2-bit code. It sits on the return path from the decoder's consumers. It buffers one encoded result, flags non-one-hot inputs, drops all-zero inputs, and keeps saturating per-code hit counters for debug readout.

---
 rtl/enc4x2_seq.sv | 115 +++++++++++
 1 files changed

// File: rtl/enc4x2_seq.sv
// Registered 4-to-2 priority encoder with a one-entry valid/ready output buffer and
// saturating per-code hit counters. Define ENC_ERR_CNT_EN to add the multi-hot err_cnt counter.
module enc4x2_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_n,
  input  logic [3:0]       in,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [1:0]       code,
  output logic             code_vld,
  input  logic             code_rdy,
  output logic             multi,
  output logic             zero_drop,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_out,
  input  logic             cnt_clr
`ifdef ENC_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  logic [1:0]            code_q, code_d;
  logic                  code_vld_q, code_vld_d;
  logic                  multi_q, multi_d;
  logic                  zero_drop_q, zero_drop_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;

  logic       accept;
  logic       accept_nz;
  logic [1:0] enc_code;
  logic       enc_multi;

  // in_rdy is held low throughout reset, independent of the enable
  assign in_rdy    = rst_n & ~en_n & (~code_vld_q | code_rdy);
  assign accept    = in_vld & in_rdy;
  assign accept_nz = accept & (|in);

  always_comb begin
    enc_code = 2'b00;
    if (in[3])      enc_code = 2'b11;
    else if (in[2]) enc_code = 2'b10;
    else if (in[1]) enc_code = 2'b01;
    enc_multi = (in[3] & (in[2] | in[1] | in[0])) |
                (in[2] & (in[1] | in[0])) |
                (in[1] & in[0]);
  end

  always_comb begin
    code_d      = code_q;
    multi_d     = multi_q;
    code_vld_d  = code_vld_q;
    zero_drop_d = accept & ~(|in);
    cnt_d       = cnt_q;
    if (accept_nz) begin
      code_d     = enc_code;
      multi_d    = enc_multi;
      code_vld_d = 1'b1;
    end else if (code_vld_q && code_rdy) begin
      code_vld_d = 1'b0;
    end
    // Clear takes priority over a same-cycle increment
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (accept_nz && (cnt_q[enc_code] != {CNT_W{1'b1}})) begin
      cnt_d[enc_code] = cnt_q[enc_code] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q      <= 2'b00;
      code_vld_q  <= 1'b0;
      multi_q     <= 1'b0;
      zero_drop_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      code_q      <= code_d;
      code_vld_q  <= code_vld_d;
      multi_q     <= multi_d;
      zero_drop_q <= zero_drop_d;
      cnt_q       <= cnt_d;
    end
  end

  assign code      = code_q;
  assign code_vld  = code_vld_q;
  assign multi     = multi_q;
  assign zero_drop = zero_drop_q;
  assign cnt_out   = cnt_q[cnt_sel];

`ifdef ENC_ERR_CNT_EN
  logic [CNT_W-1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (cnt_clr) begin
      err_d = '0;
    end else if (accept_nz && enc_multi && (err_q != {CNT_W{1'b1}})) begin
      err_d = err_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_cnt = err_q;
`endif

endmodule
